// File: rtl/uart_rx_frame_module_pkg.sv
// Shared UART definitions: default line settings, bit-period derivation and
// the FSM state encoding common to the rx and tx stages.
package uart_rx_frame_module_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                          input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous serial line plus a one-flop history
// stage that flags the first synchronized low after a high (falling edge).
module uart_rx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_sync,
  output logic neg_edge
);

  logic meta_q, sync_q, hist_q;

  // Reset to the idle-high line level so release from reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= rx_in;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rx_sync  = sync_q;
  assign neg_edge = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame_module.sv
// UART 8N1 receiver: start-bit qualification, mid-bit sampling, stop-bit check,
// registered Rx_Done_Sig / Frame_Err_Sig pulses and a held Rx_Data byte.
module uart_rx_frame_module
  import uart_rx_frame_module_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       RX_Pin_In,
  input  logic       Rx_En_Sig,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Frame_Err_Sig
);

  localparam int unsigned BPS_CNT  = bps_cnt(CLK_FREQ, BAUD);
  localparam int unsigned BPS_HALF = BPS_CNT / 2;
  localparam int unsigned CNT_W    = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_HALF - 1);

  logic rx_sync, neg_edge;

  uart_rx_sync_edge u_sync (
    .clk      (CLK),
    .rst_n    (RST_n),
    .rx_in    (RX_Pin_In),
    .rx_sync  (rx_sync),
    .neg_edge (neg_edge)
  );

  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             done_q, err_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Enable only gates the start edge; an accepted frame always completes.
          if (neg_edge && Rx_En_Sig) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[bit_q] <= rx_sync;
            bit_q          <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so the next start edge is seen even with no idle gap.
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_sync) begin
              data_q <= shift_q;
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rx_Data       = data_q;
  assign Rx_Done_Sig   = done_q;
  assign Frame_Err_Sig = err_q;

endmodule

// File: tb/tb_uart_rx_frame_module.sv
// Scoreboard bench for uart_rx_frame_module at 10 clocks per bit: a line driver
// queues expected frame outcomes and a monitor checks every Done/Err pulse.
module tb_uart_rx_frame_module;

  localparam int BIT_CYC = 10;

  logic       CLK, RST_n, RX_Pin_In, Rx_En_Sig;
  logic [7:0] Rx_Data;
  logic       Rx_Done_Sig, Frame_Err_Sig;

  uart_rx_frame_module #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .RX_Pin_In     (RX_Pin_In),
    .Rx_En_Sig     (Rx_En_Sig),
    .Rx_Data       (Rx_Data),
    .Rx_Done_Sig   (Rx_Done_Sig),
    .Frame_Err_Sig (Frame_Err_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { bit err; logic [7:0] data; } exp_t;
  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_good;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  bit prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge CLK) begin
    if (RST_n && (Rx_Done_Sig || Frame_Err_Sig)) begin
      chk("done_err_exclusive", {31'd0, Rx_Done_Sig & Frame_Err_Sig}, 32'd0);
      chk("pulse_width", {31'd0, (Rx_Done_Sig & prev_done) | (Frame_Err_Sig & prev_err)}, 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b data=%0h, expected no pulse",
                 Rx_Done_Sig, Frame_Err_Sig, Rx_Data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_is_err", {31'd0, Frame_Err_Sig}, {31'd0, e.err});
        chk("rx_data", {24'd0, Rx_Data}, {24'd0, e.data});
      end
    end
    prev_done = Rx_Done_Sig;
    prev_err  = Frame_Err_Sig;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    RX_Pin_In = v;
    tick(BIT_CYC);
  endtask

  task automatic idle(input int n);
    RX_Pin_In = 1'b1;
    tick(n);
  endtask

  // acc: the receiver is expected to take this frame (enable high at its start edge).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit acc);
    exp_t e;
    if (acc) begin
      e.err  = !stop_ok;
      e.data = stop_ok ? b : last_good;
      sb.push_back(e);
      if (stop_ok) last_good = b;
    end
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    if (stop_ok) begin
      drive_bit(1'b1);
    end else begin
      drive_bit(1'b0);
      RX_Pin_In = 1'b0;
      tick(5);
      drive_bit(1'b1);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300 && sb.size() != 0; c++) tick(1);
    chk(name, sb.size(), 32'd0);
  endtask

  initial begin
    RST_n     = 1'b0;
    RX_Pin_In = 1'b1;
    Rx_En_Sig = 1'b0;
    last_good = 8'h00;
    tick(3);
    chk("reset_rx_data", {24'd0, Rx_Data}, 32'h00);
    chk("reset_done", {31'd0, Rx_Done_Sig}, 32'd0);
    chk("reset_err", {31'd0, Frame_Err_Sig}, 32'd0);
    RST_n = 1'b1;
    idle(5);

    // Basic frame
    Rx_En_Sig = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1);
    idle(10);
    drain("drain_0x55");

    // Back-to-back frames; enable dips for 3 cycles after each Done
    fork
      begin
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit seen;
          seen = 1'b0;
          for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge CLK);
            if (Rx_Done_Sig) seen = 1'b1;
          end
          chk("b2b_done_seen", {31'd0, seen}, 32'd1);
          tick(1);
          Rx_En_Sig = 1'b0;
          tick(3);
          Rx_En_Sig = 1'b1;
        end
      end
    join
    idle(10);
    drain("drain_b2b");

    // Bad stop bit: error pulse, byte keeps 0x0F
    send_frame(8'h81, 1'b0, 1'b1);
    idle(10);
    drain("drain_ferr");
    chk("ferr_holds_data", {24'd0, Rx_Data}, 32'h0F);

    // Short low glitch on an idle line, then a real frame
    RX_Pin_In = 1'b0;
    tick(3);
    idle(30);
    chk("glitch_no_pulse", sb.size(), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(10);
    drain("drain_0x3C");

    // Disabled frame is ignored, then received once enabled
    Rx_En_Sig = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    idle(20);
    chk("disabled_data_held", {24'd0, Rx_Data}, {24'd0, last_good});
    Rx_En_Sig = 1'b1;
    idle(5);
    send_frame(8'h77, 1'b1, 1'b1);
    idle(10);
    drain("drain_0x77");

    // Reset during data bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        tick(BIT_CYC * 5 + 5);
        RST_n = 1'b0;
        #1;
        chk("midreset_rx_data", {24'd0, Rx_Data}, 32'h00);
        chk("midreset_done", {31'd0, Rx_Done_Sig}, 32'd0);
        chk("midreset_err", {31'd0, Frame_Err_Sig}, 32'd0);
        last_good = 8'h00;
        tick(3);
        RST_n = 1'b1;
      end
    join
    idle(20);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(10);
    drain("drain_0x12");

    // Random traffic: random bytes, enable, stop-bit errors and idle gaps
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit en, ok;
      b  = 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 3) != 0);
      ok = ($urandom_range(0, 4) != 0);
      Rx_En_Sig = en;
      send_frame(b, ok, en);
      if (!en) chk("rand_disabled_held", {24'd0, Rx_Data}, {24'd0, last_good});
      idle(ok ? $urandom_range(0, 15) : $urandom_range(2, 15));
    end
    idle(20);
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
